pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, pipelined multi-function barrel shifter for the shifter datapath. Accepts one WIDTH-bit operand per cycle with a shift amount and a 2-bit operation: logical left, logical right, arithmetic right, rotate right. Uses one registered stage per amount bit, with valid/ready handshakes on both sides. It is the drop-in for datapaths that need more than 8 bits, more than rotate, or a clocked, back-pressurable shifter.

## Interface
- WIDTH, 8, operand width; power of two, minimum 2.
- AMT_W, $clog2(WIDTH), derived shift-amount width; not overridden.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand and controls valid this cycle.
- in_ready  output  1  shifter accepts input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  result is all zeros; present only with BSHIFT_ZERO_FLAG_EN.

## Operation
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Left ops: SLL is computed as reverse → logical right shift → reverse. The stages implement only right-direction shifts.
- Fill rules:
  - SLL/SRL fill with 0.
  - SRA fills with in_data[WIDTH-1], the sign bit captured at input.
  - ROR fills with bits shifted out of the low end.
- Stage k (k = 0..AMT_W-1) shifts by 2^k when amt bit k is set; otherwise it passes the data through.
- Per-stage register: valid, data, op, the sign bit, and the remaining amount bits.
- in_amt = 0 gives out_data = in_data for every op.
- Amount is never reduced modulo anything beyond its width; values ≥ WIDTH are unrepresentable.
- No state machine: the pipeline is a chain of valid-tagged registers under one global stall.
- stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready and the last-stage valid.
  - While stall is high, every stage register holds.
  - While stall is low, every stage advances by one. A stage with valid=0 propagates a bubble.
  - Bubbles are not collapsed.
- in_valid while in_ready=0: nothing is captured; the source must hold its data.
- Data registers of invalid stages are don't-care internally. out_data is only meaningful when out_valid=1.

## Timing
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+AMT_W, provided no stall occurs. WIDTH=8 gives 3 cycles.
- Throughput: one operation per cycle with out_ready held high.
- Stall: each cycle of out_ready=0 with out_valid=1 adds exactly one cycle of latency to every in-flight operand. Order is preserved and nothing is dropped or duplicated.
- Simultaneous output transfer and input transfer in the same cycle: both occur, the pipeline advances, and there is no bubble.
- Reset (asynchronous, any time, including mid-flight or mid-stall):
  - All stage valids clear, out_valid=0, out_data=0, out_zero=0.
  - In-flight operands are discarded.
  - in_ready=1 while rst is high and after release.
- First input transfer is possible at the first rising edge after rst deasserts.

## Configuration
- BSHIFT_ZERO_FLAG_EN defined:
  - out_zero port exists.
  - It is registered alongside out_data in the final stage and equals (final result == 0).
  - It holds under stall and resets to 0.
- BSHIFT_ZERO_FLAG_EN undefined: out_zero port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Ops, amt=3, in_data=0x96, out_ready=1:
  - SLL → out_data=0xB0 three cycles later.
  - SRL → 0x12.
  - SRA → 0xF2.
  - ROR → 0xD2.
  - Issue the four back-to-back; they emerge on consecutive cycles in order.
- Boundaries:
  - amt=0 on all ops with 0xA5 → 0xA5.
  - SRA 0x80 amt=7 → 0xFF.
  - SRL 0x80 amt=7 → 0x01.
  - ROR 0x01 amt=7 → 0x02.
- Zero flag (macro defined): SLL 0x80 amt=1 → out_data=0x00, out_zero=1. Next op SRL 0x80 amt=1 → 0x40, out_zero=0.
- Back-pressure: stream 5 random ops, drop out_ready for 4 cycles once out_valid rises.
  - in_ready=0 during the stall, out_data stable.
  - All 5 results are correct and in order, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst between edges.
  - out_valid=0 and out_data=0 immediately.
  - After release, no stale result ever appears and a new op completes with 3-cycle latency.
- WIDTH=32, random 1000 ops with random out_ready: results match the reference model for all four ops.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
// Multi-function (SLL/SRL/SRA/ROR) barrel shifter built from one registered
// right-shift stage per amount bit, followed by an output register.
// Left shifts are done by reversing the operand at entry and again at exit,
// so every stage only ever shifts to the right.
// Global stall: while the output holds an unaccepted result, every register
// in the pipeline holds; otherwise every register advances (bubbles included).
// Optional feature: define BSHIFT_ZERO_FLAG_EN to add the registered out_zero flag.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef BSHIFT_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  localparam int AMT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Mirror the bit order of a word (used to turn a left shift into a right shift).
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // Right shift by sh with the fill selected by op: zero, sign copies, or the
  // bits falling off the low end (rotate).
  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input logic             sign,
                                                input int unsigned      sh);
    logic [WIDTH-1:0]   fill;
    logic [2*WIDTH-1:0] ext;
    case (op)
      OP_SRA:  fill = {WIDTH{sign}};
      OP_ROR:  fill = d;
      default: fill = {WIDTH{1'b0}};
    endcase
    ext = {fill, d} >> sh;
    return ext[WIDTH-1:0];
  endfunction

  // Global stall: the output holds a result nobody has taken yet.
  logic stall_s;
  logic out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  assign stall_s   = out_valid_q && !out_ready;
  assign in_ready  = !stall_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Chain of stage outputs; index 0 is the (pre-reversed) input.
  logic             ch_valid_s [AMT_W+1];
  logic [WIDTH-1:0] ch_data_s  [AMT_W+1];
  logic [1:0]       ch_op_s    [AMT_W+1];
  logic             ch_sign_s  [AMT_W];
  logic [AMT_W-1:0] ch_amt_s   [AMT_W];

  assign ch_valid_s[0] = in_valid;
  assign ch_data_s[0]  = (in_op == OP_SLL) ? bit_reverse(in_data) : in_data;
  assign ch_op_s[0]    = in_op;
  assign ch_sign_s[0]  = in_data[WIDTH-1];
  assign ch_amt_s[0]   = in_amt;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_d;

    // Shift by 2^k when amount bit k is set, otherwise pass through.
    always_comb begin
      if (ch_amt_s[k][k]) begin
        data_d = shr_fill(ch_data_s[k], ch_op_s[k], ch_sign_s[k], 32'd1 << k);
      end else begin
        data_d = ch_data_s[k];
      end
    end

    // Stage register: advance on no stall, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= {WIDTH{1'b0}};
        op_q    <= 2'b00;
      end else if (!stall_s) begin
        valid_q <= ch_valid_s[k];
        data_q  <= data_d;
        op_q    <= ch_op_s[k];
      end
    end

    assign ch_valid_s[k+1] = valid_q;
    assign ch_data_s[k+1]  = data_q;
    assign ch_op_s[k+1]    = op_q;

    if (k < AMT_W - 1) begin : g_ctl
      logic             sign_q;
      logic [AMT_W-1:0] amt_q;

      // Sign bit and amount travel with the operand to later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sign_q <= 1'b0;
          amt_q  <= {AMT_W{1'b0}};
        end else if (!stall_s) begin
          sign_q <= ch_sign_s[k];
          amt_q  <= ch_amt_s[k];
        end
      end

      assign ch_sign_s[k+1] = sign_q;
      assign ch_amt_s[k+1]  = amt_q;
    end
  end

  // Undo the entry reversal for left shifts.
  logic [WIDTH-1:0] result_s;
  assign result_s = (ch_op_s[AMT_W] == OP_SLL) ? bit_reverse(ch_data_s[AMT_W])
                                               : ch_data_s[AMT_W];

  // Output register: result and its valid, held under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else if (!stall_s) begin
      out_valid_q <= ch_valid_s[AMT_W];
      out_data_q  <= result_s;
    end
  end

`ifdef BSHIFT_ZERO_FLAG_EN
  logic out_zero_q;
  assign out_zero = out_zero_q;

  // Zero flag registered alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero_q <= 1'b0;
    end else if (!stall_s) begin
      out_zero_q <= (result_s == {WIDTH{1'b0}});
    end
  end
`endif

endmodule
